// File: rtl/vespa_loop_pkg.sv
// Shared types and helpers for the VESPA loop-control blocks.
package vespa_loop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sr_state_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DIV   = 4;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vespa_sr_divider.sv
// DIV-cycle step counter; strobes in the last cycle of each step while run is high.
module vespa_sr_divider
  import vespa_loop_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic strobe
);

  localparam int unsigned      CW   = cnt_width(DIV);
  localparam logic [CW-1:0]    LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Count 0..DIV-1 while running; held at zero otherwise so each transaction starts a fresh step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!run || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign strobe = run && (div_cnt == LAST);

endmodule

// File: rtl/vespa_sr_chain_driver.sv
// Host-side driver for the loop-control SR chain: serialises a word into the
// chain head while capturing the previous chain contents from the tail.
module vespa_sr_chain_driver
  import vespa_loop_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sr_out,
  output logic             sr_en,
  input  logic             sr_in,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             CELSUB
);

  localparam int unsigned   BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  sr_state_e        state, next_state;
  logic             armed;
  logic             strobe;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] capture;
  logic [BW-1:0]    bit_cnt;
  logic             accept;

  // Supply pins carry no logic; folded here so they are visibly consumed.
  logic unused_supply;
  assign unused_supply = ^{CELV, CELG, CELSUB};

  vespa_sr_divider #(
    .DIV (DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .run    (state == SHIFT),
    .strobe (strobe)
  );

  assign accept  = load_valid && load_ready;
  assign rd_data = capture;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    rd_valid   = 1'b0;
    busy       = 1'b0;
    sr_out     = 1'b0;
    sr_en      = 1'b0;
    case (state)
      IDLE: begin
        load_ready = armed;
        if (load_valid && armed) next_state = SHIFT;
      end
      SHIFT: begin
        busy   = 1'b1;
        sr_out = shift_reg[0];
        sr_en  = strobe;
        if (strobe && bit_cnt == LAST_BIT) next_state = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        rd_valid = 1'b1;
        if (rd_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: armed keeps load_ready low until the first clock after reset;
  // shift/capture advance only on strobe edges so sr_in is ignored otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      shift_reg <= '0;
      capture   <= '0;
      bit_cnt   <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        shift_reg <= load_data;
        bit_cnt   <= '0;
      end else if (state == SHIFT && strobe) begin
        capture   <= {sr_in, capture[WIDTH-1:1]};
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vespa_sr_chain_driver.sv
// Self-checking bench: table-driven round trips through a behavioural SR chain
// plus directed reset, back-pressure, glitch and DIV=1 sequences.
module tb_vespa_sr_chain_driver;

  logic        clk = 1'b0;
  logic        rst;
  // 16-bit / DIV=4 instance
  logic        load_valid, load_ready, sr_out, sr_en, sr_in, rd_valid, rd_ready, busy;
  logic [15:0] load_data, rd_data;
  // 8-bit / DIV=1 instance
  logic        load_valid_b, load_ready_b, sr_out_b, sr_en_b, sr_in_b, rd_valid_b, rd_ready_b, busy_b;
  logic [7:0]  load_data_b, rd_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vespa_sr_chain_driver #(.WIDTH(16), .DIV(4)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .sr_out(sr_out), .sr_en(sr_en), .sr_in(sr_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .busy(busy),
    .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0)
  );

  vespa_sr_chain_driver #(.WIDTH(8), .DIV(1)) dut8 (
    .clk(clk), .rst(rst), .load_valid(load_valid_b), .load_ready(load_ready_b),
    .load_data(load_data_b), .sr_out(sr_out_b), .sr_en(sr_en_b), .sr_in(sr_in_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b), .busy(busy_b),
    .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0)
  );

  // Behavioural chains: chain[0] is the stage nearest the driver's sr_in.
  logic [15:0] chain;
  logic        pre_req = 1'b0;
  logic [15:0] pre_val = '0;
  logic [7:0]  chain8;
  logic        pre_req8 = 1'b0;
  logic [7:0]  pre_val8 = '0;

  always @(posedge clk) begin
    if (pre_req) chain <= pre_val;
    else if (sr_en) chain <= {sr_out, chain[15:1]};
  end

  always @(posedge clk) begin
    if (pre_req8) chain8 <= pre_val8;
    else if (sr_en_b) chain8 <= {sr_out_b, chain8[7:1]};
  end

  // Glitch source: toggles every non-strobe cycle, presents a pattern bit during strobe cycles.
  logic        glitch_mode = 1'b0;
  logic        glitch_val;
  int          gidx;
  logic [15:0] gpat = 16'h3C96;

  always @(negedge clk) begin
    if (!glitch_mode) begin
      gidx       = 0;
      glitch_val = 1'b0;
    end else if (sr_en) begin
      glitch_val = gpat[gidx];
      gidx       = gidx + 1;
    end else begin
      glitch_val = ~glitch_val;
    end
  end

  assign sr_in   = glitch_mode ? glitch_val : chain[0];
  assign sr_in_b = chain8[0];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] v);
    @(negedge clk);
    pre_val = v;
    pre_req = 1'b1;
    @(posedge clk);
    #1 pre_req = 1'b0;
  endtask

  task automatic accept16(input logic [15:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!load_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("load_ready_wait", load_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clk);
    #1 load_valid = 1'b0;
    load_data = 16'hDEAD;
  endtask

  // One full transaction on the 16-bit instance; n counts cycles after the accept cycle.
  task automatic do_txn(input logic [15:0] d, input logic [15:0] exp, input int hold);
    int   n, strobes, last;
    logic spacing_ok, got, stable_ok, en_seen;
    accept16(d);
    n = 1; strobes = 0; last = 0; spacing_ok = 1'b1; got = 1'b0;
    while (n < 300 && !got) begin
      @(negedge clk);
      if (sr_en) begin
        if (n != last + 4) spacing_ok = 1'b0;
        last = n;
        strobes++;
      end
      if (rd_valid) got = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk("rd_valid_seen", got, 1'b1);
    chk("rd_valid_cycle", n, 65);
    chk("strobe_count", strobes, 16);
    chk("strobe_spacing", spacing_ok, 1'b1);
    chk("rd_data", rd_data, exp);
    chk("busy_in_done", busy, 1'b1);
    if (hold > 0) begin
      stable_ok = 1'b1;
      en_seen   = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (sr_en) en_seen = 1'b1;
        if (!rd_valid || rd_data !== exp || load_ready) stable_ok = 1'b0;
      end
      chk("bp_stable", stable_ok, 1'b1);
      chk("bp_no_sr_en", en_seen, 1'b0);
    end
    rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_ready = 1'b0;
    chk("rd_valid_drop", rd_valid, 1'b0);
    chk("load_ready_after_rd", load_ready, 1'b1);
    chk("chain_holds_load", chain, d);
  endtask

  typedef struct {
    logic [15:0] load;
    logic [15:0] exp_rd;
    int          hold;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   s, k;
    logic saw_rv;
    int   n, strobes, first, last;
    logic consec, got;
    logic [7:0] seq;

    vecs[0] = '{16'h1234, 16'hA5A5, 0};
    vecs[1] = '{16'hFFFF, 16'h1234, 0};
    vecs[2] = '{16'h0001, 16'hFFFF, 20};
    vecs[3] = '{16'h8000, 16'h0001, 0};
    vecs[4] = '{16'h0000, 16'h8000, 0};

    rst = 1'b1;
    load_valid = 1'b0; load_data = '0; rd_ready = 1'b0;
    load_valid_b = 1'b0; load_data_b = '0; rd_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {load_ready, sr_en, sr_out, rd_valid, busy, rd_data}, '0);
    rst = 1'b0;
    #1 chk("load_ready_at_release", load_ready, 1'b0);
    @(posedge clk);
    #1 chk("load_ready_after_release", load_ready, 1'b1);

    preload(16'hA5A5);
    for (int i = 0; i < 5; i++) do_txn(vecs[i].load, vecs[i].exp_rd, vecs[i].hold);

    // Reset after 7 strobes: abort without rd_valid, chain keeps 7 shifted bits.
    accept16(16'hBEEF);
    s = 0; k = 0; saw_rv = 1'b0;
    while (s < 7 && k < 100) begin
      @(negedge clk);
      if (sr_en) s++;
      if (rd_valid) saw_rv = 1'b1;
      k++;
    end
    chk("mid_strobes", s, 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("mid_rst_outputs", {load_ready, sr_en, sr_out, rd_valid, busy, rd_data}, '0);
    chk("mid_no_rd_valid", saw_rv, 1'b0);
    chk("mid_chain", chain, 16'hDE00);
    @(negedge clk);
    rst = 1'b0;
    saw_rv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rd_valid || sr_en) saw_rv = 1'b1;
    end
    chk("mid_quiet_after_rst", saw_rv, 1'b0);
    do_txn(16'h5555, 16'hDE00, 0);

    // sr_in only matters at strobe edges.
    glitch_mode = 1'b1;
    do_txn(16'h0F0F, 16'h3C96, 0);
    glitch_mode = 1'b0;
    do_txn(16'h0000, 16'h0F0F, 0);

    // DIV=1, WIDTH=8 instance.
    @(negedge clk);
    pre_val8 = 8'h3C;
    pre_req8 = 1'b1;
    @(posedge clk);
    #1 pre_req8 = 1'b0;
    @(negedge clk);
    chk("b_load_ready", load_ready_b, 1'b1);
    load_valid_b = 1'b1;
    load_data_b  = 8'h81;
    @(posedge clk);
    #1 load_valid_b = 1'b0;
    load_data_b = 8'h00;
    n = 1; strobes = 0; first = 0; last = 0; consec = 1'b1; got = 1'b0; seq = '0;
    while (n < 50 && !got) begin
      @(negedge clk);
      if (sr_en_b) begin
        if (strobes == 0) first = n;
        else if (n != last + 1) consec = 1'b0;
        if (strobes < 8) seq[strobes] = sr_out_b;
        last = n;
        strobes++;
      end
      if (rd_valid_b) got = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk("b_first_strobe", first, 1);
    chk("b_strobe_count", strobes, 8);
    chk("b_consecutive", consec, 1'b1);
    chk("b_sr_out_seq", seq, 8'b1000_0001);
    chk("b_rd_valid_cycle", n, 9);
    chk("b_rd_data", rd_data_b, 8'h3C);
    rd_ready_b = 1'b1;
    @(posedge clk);
    #1 rd_ready_b = 1'b0;
    chk("b_rd_valid_drop", rd_valid_b, 1'b0);
    chk("b_chain", chain8, 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
